// File: rtl/lif_pkg.sv
// Shared definitions for the leaky integrate-and-fire membrane stage.
//   lif_state_t : membrane stage state (integrating / refractory)
//   LIF_INC_W   : width of the per-cycle synaptic increment {carry, sum}
package lif_pkg;

   localparam int unsigned LIF_INC_W = 2;

   typedef enum logic [0:0] {
      INTEGRATE  = 1'b0,
      REFRACTORY = 1'b1
   } lif_state_t;

endpackage

// File: rtl/lif_integrator_if.sv
// Bundle between the half-adder stage (master) and the membrane stage (slave).
//   in_valid/sum/carry : beat from upstream, held until in_ready
//   in_ready           : membrane stage accepts a beat this cycle
//   vmem               : membrane potential
//   spike              : one-cycle fire pulse
//   refrac             : high while refractory
//   spike_cnt          : spikes since reset, wraps
interface lif_integrator_if #(
   parameter int unsigned WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic             sum;
   logic             carry;
   logic [WIDTH-1:0] vmem;
   logic             spike;
   logic             refrac;
   logic [15:0]      spike_cnt;

   modport master (
      output in_valid, sum, carry,
      input  in_ready, vmem, spike, refrac, spike_cnt
   );

   modport slave (
      input  in_valid, sum, carry,
      output in_ready, vmem, spike, refrac, spike_cnt
   );
endinterface

// File: rtl/lif_leak_timer.sv
// Leak period timer: counts integrate cycles 0..LEAK_PERIOD-1 and flags the last one.
//   clk, rst_n : clock, asynchronous active-low reset
//   run        : advance the counter this cycle
//   clear      : force the counter back to 0 (wins over run)
//   tick       : high while running with the counter at LEAK_PERIOD-1
module lif_leak_timer #(
   parameter int unsigned LEAK_PERIOD = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run,
   input  logic clear,
   output logic tick
);

   localparam int unsigned CW = (LEAK_PERIOD > 1) ? $clog2(LEAK_PERIOD) : 1;
   localparam logic [CW-1:0] LAST = CW'(LEAK_PERIOD - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   assign tick = run && (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (run) begin
         cnt_d = tick ? '0 : cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/lif_integrator.sv
// Leaky integrate-and-fire membrane stage.
// Accumulates the {carry, sum} increment into a saturating membrane register, subtracts LEAK
// every LEAK_PERIOD integrate cycles, fires a one-cycle spike at THRESH and then refuses input
// for REFRAC cycles.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of lif_integrator_if (beat in, membrane/spike status out)
module lif_integrator
   import lif_pkg::*;
#(
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned THRESH      = 200,
   parameter int unsigned LEAK        = 1,
   parameter int unsigned LEAK_PERIOD = 16,
   parameter int unsigned REFRAC      = 4
) (
   input  logic clk,
   input  logic rst_n,
   lif_integrator_if.slave bus
);

   // Two guard bits hold vmem + 3 before saturation.
   localparam int unsigned AW = WIDTH + 2;
   localparam int unsigned RW = (REFRAC > 1) ? $clog2(REFRAC) : 1;
   localparam logic [AW-1:0] VMAX     = {2'b00, {WIDTH{1'b1}}};
   localparam logic [AW-1:0] LEAK_W   = AW'(LEAK);
   localparam logic [AW-1:0] THRESH_W = AW'(THRESH);

   lif_state_t       state_q, state_d;
   logic [WIDTH-1:0] vmem_q, vmem_d;
   logic             spike_q, spike_d;
   logic [15:0]      cnt_q, cnt_d;
   logic [RW-1:0]    rcnt_q, rcnt_d;

   logic                 integrating;
   logic                 tick;
   logic                 timer_clear;
   logic [LIF_INC_W-1:0] inc;
   logic [AW-1:0]        added;
   logic [AW-1:0]        sat;
   logic [AW-1:0]        leaked;
   logic                 unused_hi;

   assign integrating = (state_q == INTEGRATE);
   assign inc         = (bus.in_valid && integrating) ? {bus.carry, bus.sum} : '0;

   // Add, saturate, then leak with a floor at zero.
   assign added  = {2'b00, vmem_q} + {{WIDTH{1'b0}}, inc};
   assign sat    = (added > VMAX) ? VMAX : added;
   assign leaked = tick ? ((sat > LEAK_W) ? sat - LEAK_W : '0) : sat;

   // Guard bits of leaked are always zero after saturation.
   assign unused_hi = ^leaked[AW-1:WIDTH];

   lif_leak_timer #(
      .LEAK_PERIOD(LEAK_PERIOD)
   ) u_leak_timer (
      .clk  (clk),
      .rst_n(rst_n),
      .run  (integrating),
      .clear(timer_clear),
      .tick (tick)
   );

   always_comb begin
      state_d     = state_q;
      vmem_d      = vmem_q;
      spike_d     = 1'b0;
      cnt_d       = cnt_q;
      rcnt_d      = rcnt_q;
      timer_clear = 1'b0;
      unique case (state_q)
         INTEGRATE: begin
            if (leaked >= THRESH_W) begin
               vmem_d      = '0;
               spike_d     = 1'b1;
               cnt_d       = cnt_q + 16'd1;
               timer_clear = 1'b1;
               rcnt_d      = RW'(REFRAC - 1);
               state_d     = REFRACTORY;
            end else begin
               vmem_d = leaked[WIDTH-1:0];
            end
         end
         REFRACTORY: begin
            vmem_d = '0;
            if (rcnt_q == '0) begin
               state_d = INTEGRATE;
            end else begin
               rcnt_d = rcnt_q - RW'(1);
            end
         end
         default: state_d = INTEGRATE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= INTEGRATE;
         vmem_q  <= '0;
         spike_q <= 1'b0;
         cnt_q   <= '0;
         rcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         vmem_q  <= vmem_d;
         spike_q <= spike_d;
         cnt_q   <= cnt_d;
         rcnt_q  <= rcnt_d;
      end
   end

   assign bus.in_ready  = integrating;
   assign bus.refrac    = (state_q == REFRACTORY);
   assign bus.vmem      = vmem_q;
   assign bus.spike     = spike_q;
   assign bus.spike_cnt = cnt_q;

endmodule

// File: tb/tb_lif_integrator.sv
// Bench for lif_integrator: three differently parameterised instances share one stimulus stream.
// A behavioural model per instance is checked every cycle; directed sequences pin known values.
module tb_lif_integrator;

   localparam int N = 3;

   logic clk      = 1'b0;
   logic rst_n    = 1'b0;
   logic in_valid = 1'b0;
   logic sum      = 1'b0;
   logic carry    = 1'b0;
   bit   cmp_en   = 1'b0;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   lif_integrator_if #(.WIDTH(8)) ifc0 ();
   lif_integrator_if #(.WIDTH(8)) ifc1 ();
   lif_integrator_if #(.WIDTH(8)) ifc2 ();

   assign ifc0.in_valid = in_valid;
   assign ifc0.sum      = sum;
   assign ifc0.carry    = carry;
   assign ifc1.in_valid = in_valid;
   assign ifc1.sum      = sum;
   assign ifc1.carry    = carry;
   assign ifc2.in_valid = in_valid;
   assign ifc2.sum      = sum;
   assign ifc2.carry    = carry;

   lif_integrator #(
      .WIDTH(8), .THRESH(8), .LEAK(0), .LEAK_PERIOD(16), .REFRAC(3)
   ) u0 (
      .clk(clk), .rst_n(rst_n), .bus(ifc0)
   );

   lif_integrator #(
      .WIDTH(8), .THRESH(200), .LEAK(1), .LEAK_PERIOD(4), .REFRAC(4)
   ) u1 (
      .clk(clk), .rst_n(rst_n), .bus(ifc1)
   );

   lif_integrator #(
      .WIDTH(8), .THRESH(255), .LEAK(0), .LEAK_PERIOD(1), .REFRAC(2)
   ) u2 (
      .clk(clk), .rst_n(rst_n), .bus(ifc2)
   );

   // Instance parameters for the model.
   function automatic int p_th(int k);
      case (k) 0: return 8; 1: return 200; default: return 255; endcase
   endfunction
   function automatic int p_leak(int k);
      return (k == 1) ? 1 : 0;
   endfunction
   function automatic int p_per(int k);
      case (k) 0: return 16; 1: return 4; default: return 1; endcase
   endfunction
   function automatic int p_ref(int k);
      case (k) 0: return 3; 1: return 4; default: return 2; endcase
   endfunction

   // DUT field f of instance k: 0 vmem, 1 spike, 2 refrac, 3 in_ready, 4 spike_cnt.
   function automatic int dv(int k, int f);
      case (k)
         0: case (f)
               0: return int'(ifc0.vmem); 1: return int'(ifc0.spike);
               2: return int'(ifc0.refrac); 3: return int'(ifc0.in_ready);
               default: return int'(ifc0.spike_cnt);
            endcase
         1: case (f)
               0: return int'(ifc1.vmem); 1: return int'(ifc1.spike);
               2: return int'(ifc1.refrac); 3: return int'(ifc1.in_ready);
               default: return int'(ifc1.spike_cnt);
            endcase
         default: case (f)
               0: return int'(ifc2.vmem); 1: return int'(ifc2.spike);
               2: return int'(ifc2.refrac); 3: return int'(ifc2.in_ready);
               default: return int'(ifc2.spike_cnt);
            endcase
      endcase
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Behavioural model: potential, remaining refractory cycles, leak phase, spike count.
   int m_v[N];
   int m_left[N];
   int m_phase[N];
   int m_cnt[N];
   int m_spk[N];

   always @(posedge clk or negedge rst_n) begin
      for (int k = 0; k < N; k++) begin
         if (!rst_n) begin
            m_v[k] = 0; m_left[k] = 0; m_phase[k] = 0; m_cnt[k] = 0; m_spk[k] = 0;
         end else if (m_left[k] == 0) begin
            int t;
            t = m_v[k] + (in_valid ? (int'(carry) * 2 + int'(sum)) : 0);
            if (t > 255) t = 255;
            if (m_phase[k] == p_per(k) - 1) begin
               t = t - p_leak(k);
               if (t < 0) t = 0;
               m_phase[k] = 0;
            end else begin
               m_phase[k] = m_phase[k] + 1;
            end
            if (t >= p_th(k)) begin
               m_v[k] = 0; m_spk[k] = 1; m_cnt[k] = (m_cnt[k] + 1) % 65536;
               m_phase[k] = 0; m_left[k] = p_ref(k);
            end else begin
               m_v[k] = t; m_spk[k] = 0;
            end
         end else begin
            m_v[k] = 0; m_spk[k] = 0; m_left[k] = m_left[k] - 1;
         end
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         for (int k = 0; k < N; k++) begin
            chk($sformatf("u%0d.vmem", k), dv(k, 0), m_v[k]);
            chk($sformatf("u%0d.spike", k), dv(k, 1), m_spk[k]);
            chk($sformatf("u%0d.refrac", k), dv(k, 2), (m_left[k] > 0) ? 1 : 0);
            chk($sformatf("u%0d.in_ready", k), dv(k, 3), (m_left[k] == 0) ? 1 : 0);
            chk($sformatf("u%0d.spike_cnt", k), dv(k, 4), m_cnt[k]);
         end
      end
   end

   // Present a beat for one clock; returns 1 time unit after the edge.
   task automatic step(input logic v, input logic c, input logic s);
      in_valid = v;
      carry    = c;
      sum      = s;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      in_valid = 1'b0; carry = 1'b0; sum = 1'b0;
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
   endtask

   initial begin
      @(posedge clk);
      #1;
      cmp_en = 1'b1;
      @(posedge clk);
      #1;
      chk("reset.vmem", dv(0, 0), 0);
      chk("reset.in_ready", dv(0, 3), 1);
      chk("reset.spike_cnt", dv(0, 4), 0);
      rst_n = 1'b1;

      // Carry beats held throughout, including across the refractory window.
      step(1, 1, 0); chk("A.vmem1", dv(0, 0), 2);
      step(1, 1, 0); chk("A.vmem2", dv(0, 0), 4);
      step(1, 1, 0); chk("A.vmem3", dv(0, 0), 6);
      step(1, 1, 0);
      chk("A.spike", dv(0, 1), 1);
      chk("A.vmem_fire", dv(0, 0), 0);
      chk("A.cnt", dv(0, 4), 1);
      chk("A.ready0", dv(0, 3), 0);
      chk("A.refrac", dv(0, 2), 1);
      step(1, 1, 0); chk("A.ready1", dv(0, 3), 0); chk("A.spike_low", dv(0, 1), 0);
      step(1, 1, 0); chk("A.ready2", dv(0, 3), 0); chk("D.vmem_held", dv(0, 0), 0);
      step(1, 1, 0); chk("A.ready_back", dv(0, 3), 1); chk("D.vmem_pre", dv(0, 0), 0);
      step(1, 1, 0); chk("D.held_beat", dv(0, 0), 2);
      step(1, 1, 0);
      step(1, 1, 0);
      step(1, 1, 0);
      chk("E.spike_pre", dv(0, 1), 1);
      chk("E.cnt_pre", dv(0, 4), 2);
      chk("E.u1_vmem_pre", dv(1, 0), 20);
      chk("E.u2_vmem_pre", dv(2, 0), 22);

      // Asynchronous reset in the middle of a refractory window.
      rst_n = 1'b0;
      #1;
      chk("E.vmem", dv(0, 0), 0);
      chk("E.spike", dv(0, 1), 0);
      chk("E.refrac", dv(0, 2), 0);
      chk("E.cnt", dv(0, 4), 0);
      chk("E.u2_vmem", dv(2, 0), 0);
      #1;
      rst_n = 1'b1;
      in_valid = 1'b0;
      #1;
      chk("E.ready_after", dv(0, 3), 1);

      // Increment of 3 reaching threshold exactly.
      step(1, 1, 0);
      step(1, 1, 1); chk("F.vmem5", dv(0, 0), 5);
      step(1, 1, 1); chk("F.spike", dv(0, 1), 1); chk("F.vmem", dv(0, 0), 0);

      // Leak with floor at zero.
      do_reset();
      step(1, 0, 1); chk("B.v1", dv(1, 0), 1);
      step(1, 0, 1); chk("B.v2", dv(1, 0), 2);
      step(1, 0, 1); chk("B.v3", dv(1, 0), 3);
      step(0, 0, 0); chk("B.leak", dv(1, 0), 2);
      repeat (4) step(0, 0, 0);
      chk("B.leak2", dv(1, 0), 1);
      repeat (4) step(0, 0, 0);
      chk("B.leak3", dv(1, 0), 0);
      repeat (4) step(0, 0, 0);
      chk("B.floor", dv(1, 0), 0);

      // Saturation alone reaches threshold.
      do_reset();
      repeat (127) step(1, 1, 0);
      chk("C.vmem254", dv(2, 0), 254);
      step(1, 1, 0);
      chk("C.spike", dv(2, 1), 1);
      chk("C.vmem", dv(2, 0), 0);
      chk("C.cnt", dv(2, 4), 1);

      // Random traffic with occasional asynchronous resets.
      do_reset();
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(999) == 0) begin
            rst_n = 1'b0;
            #1;
            rst_n = 1'b1;
         end
         step(($urandom_range(99) < 70) ? 1'b1 : 1'b0, 1'($urandom), 1'($urandom));
      end
      step(0, 0, 0);
      @(negedge clk);
      #1;
      cmp_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
